// File: rtl/btn_cond_pkg.sv
// Shared definitions for the pushbutton conditioner.
//   btn_state_t             : per-channel debounce FSM state (2-bit encoding)
//   N_BTN_DEFAULT           : default number of button channels
//   DEBOUNCE_CYCLES_DEFAULT : default stable-cycle count (10 ms at 100 MHz)
package btn_cond_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,   // stable released
      ST_PRESS_CHK   = 2'd1,   // candidate press, counting stable-high cycles
      ST_HELD        = 2'd2,   // stable pressed
      ST_RELEASE_CHK = 2'd3    // candidate release, counting stable-low cycles
   } btn_state_t;

   localparam int N_BTN_DEFAULT           = 3;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus between the raw pushbuttons and the conditioned outputs.
//   btn_raw     : asynchronous bouncing levels, 1 = pressed
//   btn_level   : debounced level per channel
//   btn_press   : one-cycle pulse per accepted press
//   btn_release : one-cycle pulse per accepted release
// master = stimulus/consumer side, slave = btn_conditioner.
interface btn_conditioner_if #(
   parameter int N_BTN = 3
);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release
   );
endinterface

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, stability counter, 4-state
// debounce FSM and registered level/press/release outputs.
//   i_clk     : system clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_raw     : asynchronous raw button level
//   o_level   : debounced level (high in HELD and RELEASE_CHK)
//   o_press   : one-cycle pulse on entering HELD
//   o_release : one-cycle pulse on entering IDLE from RELEASE_CHK
module btn_debounce_ch
   import btn_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   btn_state_t       r_state;
   btn_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic             w_bit;
   logic             w_level_nxt;
   logic             w_press_nxt;
   logic             w_release_nxt;

   assign w_bit = r_sync[1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync    <= '0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], i_raw};
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   // Counter is cleared by default so it sits at 0 in IDLE/HELD and on every
   // abort; it only advances while a check is still short of CNT_LAST.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_bit) w_state_nxt = ST_PRESS_CHK;
         end
         ST_PRESS_CHK: begin
            if (!w_bit)                w_state_nxt = ST_IDLE;
            else if (r_cnt == CNT_LAST) w_state_nxt = ST_HELD;
            else                        w_cnt_nxt   = r_cnt + 1'b1;
         end
         ST_HELD: begin
            if (!w_bit) w_state_nxt = ST_RELEASE_CHK;
         end
         ST_RELEASE_CHK: begin
            if (w_bit)                  w_state_nxt = ST_HELD;
            else if (r_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
            else                        w_cnt_nxt   = r_cnt + 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Outputs derived from the next state so they change on the same edge
      // as the state register.
      w_level_nxt   = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_CHK);
      w_press_nxt   = (r_state == ST_PRESS_CHK)   && (w_state_nxt == ST_HELD);
      w_release_nxt = (r_state == ST_RELEASE_CHK) && (w_state_nxt == ST_IDLE);
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton conditioner: one independent debounce channel per
// button. btn_level is intended for slow-clock stop/start control; the
// press/release pulses are for consumers in the clk domain only.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   btn_bus : button bus (slave side) carrying btn_raw in and
//             btn_level/btn_press/btn_release out
module btn_conditioner
   import btn_cond_pkg::*;
#(
   parameter int N_BTN           = N_BTN_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   btn_conditioner_if.slave   btn_bus
);

   logic [N_BTN-1:0] w_level;
   logic [N_BTN-1:0] w_press;
   logic [N_BTN-1:0] w_release;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .i_clk     (clk),
         .i_rst     (rst),
         .i_raw     (btn_bus.btn_raw[g]),
         .o_level   (w_level[g]),
         .o_press   (w_press[g]),
         .o_release (w_release[g])
      );
   end

   assign btn_bus.btn_level   = w_level;
   assign btn_bus.btn_press   = w_press;
   assign btn_bus.btn_release = w_release;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with N_BTN = 3, DEBOUNCE_CYCLES = 4.
// Edge numbering: edge 1 is the first rising edge that samples a new raw
// level; a clean step gives its pulse after edge 7.
module tb_btn_conditioner;
   import btn_cond_pkg::*;

   localparam int NB = 3;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst;

   btn_conditioner_if #(.N_BTN(NB)) bus ();

   btn_conditioner #(
      .N_BTN           (NB),
      .DEBOUNCE_CYCLES (DC)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .btn_bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Running pulse totals, sampled on the falling edge.
   int n_press [NB];
   int n_rel   [NB];
   int n_both  = 0;

   initial begin
      for (int i = 0; i < NB; i++) begin
         n_press[i] = 0;
         n_rel[i]   = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.btn_press[i])   n_press[i]++;
            if (bus.btn_release[i]) n_rel[i]++;
            if (bus.btn_press[i] && bus.btn_release[i]) n_both++;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   int p0, r0, p1, r1, p2, r2;

   initial begin
      rst = 1'b1;
      bus.btn_raw = '0;
      tick(3);
      check_eq("rst_level",   32'(bus.btn_level),   32'h0);
      check_eq("rst_press",   32'(bus.btn_press),   32'h0);
      check_eq("rst_release", 32'(bus.btn_release), 32'h0);
      rst = 1'b0;
      tick(2);

      // Clean press on channel 0, held 20 cycles.
      p0 = n_press[0];
      bus.btn_raw = 3'b001;
      tick(6);
      check_eq("c0_press_e6", 32'(bus.btn_press), 32'h0);
      check_eq("c0_level_e6", 32'(bus.btn_level), 32'h0);
      tick(1);
      check_eq("c0_press_e7", 32'(bus.btn_press), 32'h1);
      check_eq("c0_level_e7", 32'(bus.btn_level), 32'h1);
      tick(1);
      check_eq("c0_press_e8", 32'(bus.btn_press), 32'h0);
      tick(12);
      check_eq("c0_press_cnt", 32'(n_press[0] - p0), 32'd1);

      // Release channel 0.
      r0 = n_rel[0];
      bus.btn_raw = 3'b000;
      tick(6);
      check_eq("c0_rel_e6",    32'(bus.btn_release), 32'h0);
      check_eq("c0_lvl_rel6",  32'(bus.btn_level),   32'h1);
      tick(1);
      check_eq("c0_rel_e7",    32'(bus.btn_release), 32'h1);
      check_eq("c0_lvl_rel7",  32'(bus.btn_level),   32'h0);
      tick(1);
      check_eq("c0_rel_e8",    32'(bus.btn_release), 32'h0);
      tick(3);
      check_eq("c0_rel_cnt",   32'(n_rel[0] - r0),   32'd1);

      // Simultaneous step on channels 0 and 2; channel 1 stays silent.
      p1 = n_press[1];
      bus.btn_raw = 3'b101;
      tick(6);
      check_eq("ind_press_e6", 32'(bus.btn_press), 32'h0);
      tick(1);
      check_eq("ind_press_e7", 32'(bus.btn_press), 32'h5);
      check_eq("ind_level_e7", 32'(bus.btn_level), 32'h5);
      tick(5);
      check_eq("ind_c1_cnt",   32'(n_press[1] - p1), 32'd0);

      // Release channel 2 while channel 0 stays held.
      r2 = n_rel[2];
      bus.btn_raw = 3'b001;
      tick(6);
      check_eq("c2_rel_e6", 32'(bus.btn_release), 32'h0);
      tick(1);
      check_eq("c2_rel_e7", 32'(bus.btn_release), 32'h4);
      check_eq("c2_lvl_e7", 32'(bus.btn_level),   32'h1);
      tick(3);
      check_eq("c2_rel_cnt", 32'(n_rel[2] - r2),  32'd1);

      // Bounce on channel 1: 1,0,1,0 one cycle each then low.
      p1 = n_press[1];
      r1 = n_rel[1];
      bus.btn_raw = 3'b011; tick(1);
      bus.btn_raw = 3'b001; tick(1);
      bus.btn_raw = 3'b011; tick(1);
      bus.btn_raw = 3'b001; tick(15);
      check_eq("bnc_level",  32'(bus.btn_level[1]),  32'h0);
      check_eq("bnc_press",  32'(n_press[1] - p1),   32'd0);
      check_eq("bnc_rel",    32'(n_rel[1] - r1),     32'd0);
      check_eq("bnc_state",  32'(u_dut.g_ch[1].u_ch.r_state), 32'(ST_IDLE));

      // Return everything to idle.
      bus.btn_raw = 3'b000;
      tick(10);
      check_eq("idle_level", 32'(bus.btn_level), 32'h0);

      // Reset during channel 0's press check (counter at 1), button kept high.
      p0 = n_press[0];
      r0 = n_rel[0];
      bus.btn_raw = 3'b001;
      tick(4);
      rst = 1'b1;
      tick(1);
      check_eq("rmc_press", 32'(bus.btn_press), 32'h0);
      check_eq("rmc_level", 32'(bus.btn_level), 32'h0);
      rst = 1'b0;
      tick(6);
      check_eq("rmc_press_e6", 32'(bus.btn_press), 32'h0);
      tick(1);
      check_eq("rmc_press_e7", 32'(bus.btn_press), 32'h1);

      // Long hold: total 100 cycles since reset release, one press only.
      tick(93);
      check_eq("long_press_cnt", 32'(n_press[0] - p0), 32'd1);
      check_eq("long_rel_cnt",   32'(n_rel[0] - r0),   32'd0);
      check_eq("long_level",     32'(bus.btn_level),   32'h1);
      bus.btn_raw = 3'b000;
      tick(10);
      check_eq("long_rel_after", 32'(n_rel[0] - r0),   32'd1);
      check_eq("long_press_fin", 32'(n_press[0] - p0), 32'd1);

      check_eq("never_both", 32'(n_both), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 3: number of pushbutton channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable clk cycles required to accept a level change (10 ms at 100 MHz); legal range >= 2.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port btn_raw, input, N_BTN: asynchronous, bouncing pushbutton levels; 1 = pressed.
REQ-006 SHALL have port btn_level, output, N_BTN: debounced level per channel, registered.
REQ-007 SHALL have port btn_press, output, N_BTN: one-clk-cycle pulse per accepted press, registered.
REQ-008 SHALL have port btn_release, output, N_BTN: one-clk-cycle pulse per accepted release, registered.

Function
REQ-009 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other use; no other logic samples btn_raw.
REQ-010 SHALL process channels independently; no channel's activity affects another.
REQ-011 SHALL run one 4-state FSM per channel: IDLE (stable released), PRESS_CHK, HELD (stable pressed), RELEASE_CHK.
REQ-012 IDLE -> PRESS_CHK when synchronized bit = 1; counter cleared on entry.
REQ-013 PRESS_CHK: counter increments each cycle the synchronized bit stays 1; back to IDLE, counter cleared, if it reads 0; -> HELD when counter reaches DEBOUNCE_CYCLES-1 with bit still 1.
REQ-014 HELD -> RELEASE_CHK when synchronized bit = 0; RELEASE_CHK mirrors REQ-013 with polarity inverted, returning to HELD on a 1 and -> IDLE on completion.
REQ-015 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter never wraps and is held at 0 in IDLE and HELD.
REQ-016 btn_level SHALL be 1 exactly while the FSM is in HELD or RELEASE_CHK, updated on the same edge as the state register.
REQ-017 btn_press SHALL be high for exactly one cycle on the edge the FSM enters HELD; btn_release likewise on entering IDLE from RELEASE_CHK.
REQ-018 Latency: with a clean step on btn_raw, btn_press/btn_release SHALL rise DEBOUNCE_CYCLES+3 rising edges after the first edge sampling the new raw level.
REQ-019 A bounce shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse and no btn_level change.
REQ-020 btn_press and btn_release SHALL never be high in the same cycle on one channel; one press pulse per HELD entry, irrespective of hold time.

Reset
REQ-021 On rst = 1 at a clk edge: synchronizer flops 0, all FSMs IDLE, counters 0, btn_level/btn_press/btn_release all 0.
REQ-022 Reset mid-operation SHALL abort any check in progress without emitting a pulse; a button held through reset SHALL be accepted as a new press DEBOUNCE_CYCLES+3 edges after rst deasserts.

Structure
REQ-023 Package btn_cond_pkg SHALL hold the FSM state encoding (2-bit: IDLE=0, PRESS_CHK=1, HELD=2, RELEASE_CHK=3) and default DEBOUNCE_CYCLES constant.
REQ-024 Per-channel logic (synchronizer, counter, FSM, output flops) SHALL live in sub-module btn_debounce_ch, instantiated N_BTN times by a generate loop in btn_conditioner.
REQ-025 btn_level SHALL be the consumer's input for slow-clock stop/start control; btn_press/btn_release serve clk-domain consumers only.

Verification (bench uses DEBOUNCE_CYCLES = 4, N_BTN = 3)
REQ-026 Clean press: btn_raw[0] 0->1 held 20 cycles -> btn_press[0] high exactly 1 cycle, 7 edges after first high sample; btn_level[0] = 1 from same edge.
REQ-027 Bounce: btn_raw[1] toggles 1,0,1,0 one cycle each, then 0 -> no pulse, btn_level[1] stays 0, FSM ends IDLE.
REQ-028 Release: channel 2 in HELD, btn_raw[2] -> 0 held 10 cycles -> btn_release[2] one cycle 7 edges later, btn_level[2] = 0.
REQ-029 Independence: btn_raw = 3'b101 stepped simultaneously -> btn_press[0] and btn_press[2] pulse on the same edge, channel 1 silent.
REQ-030 Reset mid-check: btn_raw[0] high, rst pulsed 1 cycle at check cycle 2 -> no pulse during/at reset; btn_press[0] 7 edges after rst falls.
REQ-031 Long hold: btn_raw[0] high 100 cycles -> exactly one btn_press[0], zero btn_release[0] until release.
